// File: rtl/hsi_vctr_packer.sv
// rtl/hsi_vctr_packer.sv - packs per-band sample pairs 4-per-word for the mse_4 word interface.
// Optional macro HSI_PACKER_ERR_EN adds a sticky err output for illegal band_count starts.
module hsi_vctr_packer #(
  parameter int DATA_WIDTH     = 16,
  parameter int WORD_WIDTH     = DATA_WIDTH * 4,
  parameter int HSI_BANDS      = 128,
  parameter int BAND_CNT_WIDTH = $clog2(HSI_BANDS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BAND_CNT_WIDTH-1:0] band_count,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data_1,
  input  logic [DATA_WIDTH-1:0]     in_data_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_WIDTH-1:0]     out_vctr_1,
  output logic [WORD_WIDTH-1:0]     out_vctr_2,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
`ifdef HSI_PACKER_ERR_EN
  ,
  output logic                      err
`endif
);

  localparam logic [BAND_CNT_WIDTH-1:0] MAX_BANDS = BAND_CNT_WIDTH'(HSI_BANDS);
  localparam logic [BAND_CNT_WIDTH-1:0] ONE_BAND  = BAND_CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [BAND_CNT_WIDTH-1:0] bands_q, bands_d;
  logic [1:0]                lane_q, lane_d;
  logic [WORD_WIDTH-1:0]     pack1_q, pack1_d;
  logic [WORD_WIDTH-1:0]     pack2_q, pack2_d;
  logic                      start_bad;

`ifdef HSI_PACKER_ERR_EN
  logic err_q, err_d;
  assign start_bad = (band_count == '0) || (band_count > MAX_BANDS);
  assign err       = err_q;
`else
  assign start_bad = (band_count == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bands_q <= '0;
      lane_q  <= '0;
      pack1_q <= '0;
      pack2_q <= '0;
`ifdef HSI_PACKER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bands_q <= bands_d;
      lane_q  <= lane_d;
      pack1_q <= pack1_d;
      pack2_q <= pack2_d;
`ifdef HSI_PACKER_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bands_d = bands_q;
    lane_d  = lane_q;
    pack1_d = pack1_q;
    pack2_d = pack2_q;
`ifdef HSI_PACKER_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_bad) begin
`ifdef HSI_PACKER_ERR_EN
            err_d = 1'b1;
`endif
          end else begin
            bands_d = (band_count > MAX_BANDS) ? MAX_BANDS : band_count;
            lane_d  = '0;
            pack1_d = '0;
            pack2_d = '0;
            state_d = S_FILL;
`ifdef HSI_PACKER_ERR_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      S_FILL: begin
        if (in_valid) begin
          // Lane 0 is the most-significant slot of the word.
          for (int l = 0; l < 4; l++) begin
            if (lane_q == l[1:0]) begin
              pack1_d[WORD_WIDTH-1-l*DATA_WIDTH -: DATA_WIDTH] = in_data_1;
              pack2_d[WORD_WIDTH-1-l*DATA_WIDTH -: DATA_WIDTH] = in_data_2;
            end
          end
          lane_d  = lane_q + 2'd1;
          bands_d = bands_q - ONE_BAND;
          if (lane_q == 2'd3 || bands_q == ONE_BAND) begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (bands_q != '0) begin
            // Clearing here keeps unwritten lanes zero in a short final word.
            lane_d  = '0;
            pack1_d = '0;
            pack2_d = '0;
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = (state_q == S_FILL);
  assign out_valid  = (state_q == S_SEND);
  assign out_vctr_1 = (state_q == S_SEND) ? pack1_q : '0;
  assign out_vctr_2 = (state_q == S_SEND) ? pack2_q : '0;
  assign out_last   = (state_q == S_SEND) && (bands_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_hsi_vctr_packer.sv
// tb/tb_hsi_vctr_packer.sv - scoreboard bench for hsi_vctr_packer.
module tb_hsi_vctr_packer;
  localparam int DW = 16;
  localparam int WW = 64;
  localparam int HB = 128;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [BW-1:0] band_count;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data_1, in_data_2;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_vctr_1, out_vctr_2;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef HSI_PACKER_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  hsi_vctr_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .band_count(band_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data_1(in_data_1), .in_data_2(in_data_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_vctr_1(out_vctr_1), .out_vctr_2(out_vctr_2),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef HSI_PACKER_ERR_EN
    , .err(err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int word_cnt = 0;
  logic [128:0]  exp_q[$];
  logic [DW-1:0] d1[256];
  logic [DW-1:0] d2[256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      logic [128:0] e;
      word_cnt++;
      check("word_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("vctr_1", out_vctr_1, e[128:65]);
        check("vctr_2", out_vctr_2, e[64:1]);
        check("last", 64'(out_last), 64'(e[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vector(input int n);
    int neff, words, idx;
    logic [63:0] v1, v2;
    neff  = (n > HB) ? HB : n;
    words = (neff + 3) / 4;
    for (int w = 0; w < words; w++) begin
      v1 = '0;
      v2 = '0;
      for (int l = 0; l < 4; l++) begin
        idx = 4 * w + l;
        if (idx < neff) begin
          v1[63-16*l -: 16] = d1[idx];
          v2[63-16*l -: 16] = d2[idx];
        end
      end
      exp_q.push_back({v1, v2, (w == words - 1)});
    end
  endtask

  task automatic do_start(input int n);
    start      = 1'b1;
    band_count = BW'(n);
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi);
    int t;
    for (int i = lo; i < hi; i++) begin
      in_valid  = 1'b1;
      in_data_1 = d1[i];
      in_data_2 = d2[i];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) check("feed_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 2000) begin
      tick();
      t++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dc, wc;
    logic [63:0] hold;
    rst_n = 1'b0; start = 1'b0; band_count = '0; in_valid = 1'b0;
    in_data_1 = '0; in_data_2 = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    // Basic single word
    d1[0] = 16'd5; d1[1] = 16'd3; d1[2] = 16'd2; d1[3] = 16'd1;
    d2[0] = 16'd3; d2[1] = 16'd2; d2[2] = 16'd1; d2[3] = 16'd0;
    exp_q.push_back({64'h0005_0003_0002_0001, 64'h0003_0002_0001_0000, 1'b1});
    out_ready = 1'b1;
    dc = done_cnt;
    do_start(4);
    feed(0, 4);
    check("latency_valid", 64'(out_valid), 64'd1);
    wait_idle("basic_idle");
    repeat (3) tick();
    check("basic_done_once", 64'(done_cnt - dc), 64'd1);

    // Padding, with an ignored start mid-vector
    for (int i = 0; i < 6; i++) begin
      d1[i] = DW'(i + 1);
      d2[i] = '0;
    end
    exp_q.push_back({64'h0001_0002_0003_0004, 64'h0, 1'b0});
    exp_q.push_back({64'h0005_0006_0000_0000, 64'h0, 1'b1});
    dc = done_cnt;
    do_start(6);
    feed(0, 2);
    start = 1'b1; band_count = 8'd3;
    tick();
    start = 1'b0;
    feed(2, 6);
    wait_idle("pad_idle");
    repeat (3) tick();
    check("pad_done_once", 64'(done_cnt - dc), 64'd1);

    // Backpressure on the first word
    for (int i = 0; i < 8; i++) begin
      d1[i] = DW'($urandom);
      d2[i] = DW'($urandom);
    end
    push_vector(8);
    out_ready = 1'b0;
    do_start(8);
    fork
      feed(0, 8);
      begin
        int t = 0;
        while (!out_valid && t < 100) begin
          tick();
          t++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        hold = out_vctr_1;
        repeat (10) begin
          tick();
          check("bp_stable", out_vctr_1, hold);
          check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle("bp_idle");

    // Odd length
    for (int i = 0; i < 13; i++) begin
      d1[i] = DW'($urandom);
      d2[i] = DW'($urandom);
    end
    push_vector(13);
    do_start(13);
    feed(0, 13);
    wait_idle("odd_idle");

    // Abort by reset after two samples
    dc = done_cnt;
    do_start(8);
    feed(0, 2);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);

    // Zero count is ignored
    do_start(0);
    repeat (3) tick();
    check("zero_busy", 64'(busy), 64'd0);

`ifdef HSI_PACKER_ERR_EN
    do_start(200);
    tick();
    check("err_set", 64'(err), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      d1[i] = DW'($urandom);
      d2[i] = DW'($urandom);
    end
    push_vector(4);
    do_start(4);
    check("err_clear", 64'(err), 64'd0);
    feed(0, 4);
    wait_idle("err_idle");
`else
    for (int i = 0; i < HB; i++) begin
      d1[i] = DW'($urandom);
      d2[i] = DW'($urandom);
    end
    wc = word_cnt;
    push_vector(200);
    do_start(200);
    feed(0, HB);
    wait_idle("clamp_idle");
    check("clamp_words", 64'(word_cnt - wc), 64'd32);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
